mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for the 4->1 one-bit mux: shares the mux between 4 requesters.

---
 rtl/mux4_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4->1 one-bit mux between 4 requesters.
// Ports: clk, rst_n (async low), req[3:0], d[3:0] -> gnt[3:0], sel[1:0], z, valid.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       z,
  output logic       valid
);

  localparam int HW =
    ($clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    fsm_q, fsm_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          z_q, valid_q;
  logic [1:0]    pick_idx;
  logic          release_c;

  // First set bit scanning p, p+1, ... (mod 4). Descending loop
  // lets the nearest candidate overwrite the farther ones.
  function automatic logic [1:0] pick(
    input logic [3:0] m,
    input logic [1:0] p
  );
    logic [1:0] idx;
    pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (m[idx]) pick = idx;
    end
  endfunction

  assign pick_idx = pick(req, ptr_q);

  // sel_q is the owner while granting.
  assign release_c = !req[sel_q] ||
    ((MAX_HOLD != 0) && (hold_q == HOLD_LIM));

  always_comb begin
    fsm_d  = fsm_q;
    gnt_d  = gnt_q;
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    hold_d = hold_q;
    unique case (1'b1)
      (fsm_q == IDLE) || release_c: begin
        if (req != 4'b0) begin
          fsm_d  = GRANT;
          gnt_d  = 4'b0;
          gnt_d[pick_idx] = 1'b1;
          sel_d  = pick_idx;
          ptr_d  = pick_idx + 2'd1;
          hold_d = HOLD_ONE;
        end else begin
          fsm_d  = IDLE;
          gnt_d  = 4'b0;
          hold_d = '0;
        end
      end
      default: begin
        if (hold_q != '1) hold_d = hold_q + HOLD_ONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      gnt_q   <= 4'b0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      z_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      gnt_q  <= gnt_d;
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
      // Output stage samples the mux with the select already
      // registered, so z trails sel by one clock.
      if (fsm_q == GRANT) begin
        z_q     <= d[sel_q];
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign z     = z_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: vector table plus corner sequences.
// Outputs sampled 1 time unit after each rising edge.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'hF;
  logic [3:0] d = 4'hF;
  logic [3:0] gnt, gnt0;
  logic [1:0] sel, sel0;
  logic       z, z0;
  logic       valid, valid0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt), .sel(sel), .z(z), .valid(valid)
  );

  mux4_rr_arbiter #(.MAX_HOLD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt0), .sel(sel0), .z(z0), .valid(valid0)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       z;
    logic       valid;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {gnt, sel, z, valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // {req, d, gnt, sel, z, valid}; starts IDLE with ptr=0
    tbl[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    tbl[2]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0};
    tbl[4]  = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, 1'b1};
    tbl[6]  = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b1};
    tbl[7]  = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[8]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 1'b1};
    tbl[9]  = '{4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1};
    tbl[10] = '{4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[11] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b1};
    tbl[12] = '{4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0};

    // Async reset with no clock edge, inputs all high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", outs(), 8'h00);
    tick();
    tick();
    chk("rst_held", outs(), 8'h00);
    req = 4'b0000;
    d   = 4'b0000;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req;
      d   = tbl[i].d;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {tbl[i].gnt, tbl[i].sel, tbl[i].z, tbl[i].valid});
    end

    // Fairness with all requesters active.
    pulse_reset();
    req = 4'hF;
    d   = 4'b0000;
    for (int k = 1; k <= 20; k++) begin
      logic [1:0] o;
      logic [3:0] g;
      tick();
      o = 2'(((k - 1) / 4) % 4);
      g = 4'b0001 << o;
      chk($sformatf("fair%0d", k), {2'b00, gnt, sel},
          {2'b00, g, o});
      chk($sformatf("nolim%0d", k), {2'b00, gnt0, sel0},
          {2'b00, 4'b0001, 2'd0});
    end

    // Solo requester re-granted across the hold limit.
    pulse_reset();
    req = 4'b0001;
    d   = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("solo%0d", k), outs(),
          (k == 1) ? 8'b0001_00_0_0 : 8'b0001_00_1_1);
    end

    // Async reset in the middle of a grant.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_midgrant", outs(), 8'h00);
    tick();
    chk("rst_midgrant_held", outs(), 8'h00);
    rst_n = 1'b1;
    req = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
